// File: rtl/fp_mul_norm_round.sv
// fp_mul_norm_round
// Final stage of the FP multiplier. It accepts one raw mantissa product and its
// shift command through a valid/ready handshake. It then applies the shift a
// few bits per cycle, rounds to nearest-even, and resolves the special classes
// and overflow. The packed IEEE-754 result is held until downstream accepts it.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  input handshake (ready only while idle)
//   sign_in         result sign
//   mant_in         raw mantissa product, MANT_MUL bits
//   exp_in          adjusted exponent, EXP bits
//   over_flow_in    upstream overflow indication
//   spe_case_a/b_in operand class: 0 norm, 1 denorm, 2 zero, 3 inf, 4 NaN
//   shift_type_in   00 right, 01 left, 1x none
//   shift_value_in  shift distance, SHIFT bits
//   out_valid/ready output handshake
//   result          {sign, exp, frac}
//   flag_*          overflow / underflow / inexact for the held result
//   busy            block is processing or holding a result
//
// EXP defaults to 5 so that 1 + EXP + MANT fills the 16-bit result exactly
// (binary16 layout).
module fp_mul_norm_round #(
  parameter int DW   = 16,
  parameter int EXP  = 5,
  parameter int MANT = 10,
  parameter int STEP = 4,
  localparam int MANT_MUL = 2 * (MANT + 1),
  localparam int SHIFT    = (DW == 16) ? 5 : ((DW == 32) ? 6 : 7)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                sign_in,
  input  logic [MANT_MUL-1:0] mant_in,
  input  logic [EXP-1:0]      exp_in,
  input  logic                over_flow_in,
  input  logic [2:0]          spe_case_a_in,
  input  logic [2:0]          spe_case_b_in,
  input  logic [1:0]          shift_type_in,
  input  logic [SHIFT-1:0]    shift_value_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       result,
  output logic                flag_overflow,
  output logic                flag_underflow,
  output logic                flag_inexact,
  output logic                busy
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ROUND, S_OUT} state_t;

  localparam logic [SHIFT-1:0] MAX_SHIFT = SHIFT'(MANT_MUL - 1);
  localparam logic [SHIFT-1:0] STEP_V    = SHIFT'(STEP);
  localparam logic [EXP:0]     EXP_MAX   = {1'b0, {EXP{1'b1}}};

  state_t              r_state, w_nextState;
  logic [MANT_MUL-1:0] r_mant;
  logic [EXP-1:0]      r_exp;
  logic                r_sign, r_ovfIn, r_sticky;
  logic [2:0]          r_speA, r_speB;
  logic [1:0]          r_type;
  logic [SHIFT-1:0]    r_remaining;
  logic [DW-1:0]       r_result;
  logic                r_flagOvf, r_flagUnf, r_flagInx;

  function automatic logic isSpecial(input logic [2:0] c);
    return (c == 3'd2) || (c == 3'd3) || (c == 3'd4);
  endfunction

  // Shift distances past the product width are pointless, so the command is clamped.
  logic [SHIFT-1:0] w_clamped;
  logic             w_skipShift;
  assign w_clamped   = (shift_value_in > MAX_SHIFT) ? MAX_SHIFT : shift_value_in;
  assign w_skipShift = isSpecial(spe_case_a_in) || isSpecial(spe_case_b_in) ||
                       over_flow_in || shift_type_in[1] || (w_clamped == '0);

  // One iteration of the shifter: at most STEP bits. Right shifts keep the
  // bits that fall off in the sticky bit.
  logic [SHIFT-1:0]    w_step;
  logic [MANT_MUL-1:0] w_shiftedR, w_shiftedL, w_lostMask;
  logic                w_lost;
  assign w_step     = (r_remaining > STEP_V) ? STEP_V : r_remaining;
  assign w_shiftedR = r_mant >> w_step;
  assign w_shiftedL = r_mant << w_step;
  assign w_lostMask = (MANT_MUL'(1) << w_step) - MANT_MUL'(1);
  assign w_lost     = |(r_mant & w_lostMask);

  // Round to nearest-even. The top product bit is the hidden one. A carry out
  // of the fraction bumps the exponent; from 0 (denormal) it becomes 1 (normal).
  logic [MANT-1:0] w_frac, w_fracRnd;
  logic [MANT:0]   w_fracSum;
  logic [EXP:0]    w_expSum;
  logic            w_guard, w_stickyAll, w_roundUp, w_inexact, w_expOvf;
  assign w_frac      = r_mant[MANT_MUL-2 -: MANT];
  assign w_guard     = r_mant[MANT_MUL-2-MANT];
  assign w_stickyAll = r_sticky | (|r_mant[MANT_MUL-3-MANT:0]);
  assign w_roundUp   = w_guard & (w_stickyAll | w_frac[0]);
  assign w_fracSum   = {1'b0, w_frac} + (MANT+1)'(w_roundUp);
  assign w_fracRnd   = w_fracSum[MANT-1:0];
  assign w_expSum    = {1'b0, r_exp} + (EXP+1)'(w_fracSum[MANT]);
  assign w_expOvf    = (w_expSum >= EXP_MAX);
  assign w_inexact   = w_guard | w_stickyAll;

  // Final result selection. Special classes win over overflow, and NaN
  // (including inf * zero) wins over inf and zero.
  logic          w_isNaN, w_isInf, w_isZero;
  logic [DW-1:0] w_packed;
  logic          w_pOvf, w_pUnf, w_pInx;
  assign w_isNaN  = (r_speA == 3'd4) || (r_speB == 3'd4) ||
                    ((r_speA == 3'd3) && (r_speB == 3'd2)) ||
                    ((r_speA == 3'd2) && (r_speB == 3'd3));
  assign w_isInf  = (r_speA == 3'd3) || (r_speB == 3'd3);
  assign w_isZero = (r_speA == 3'd2) || (r_speB == 3'd2);

  always_comb begin
    w_packed = {r_sign, w_expSum[EXP-1:0], w_fracRnd};
    w_pOvf   = 1'b0;
    w_pInx   = w_inexact;
    w_pUnf   = (w_expSum[EXP-1:0] == '0) & w_inexact;
    if (w_isNaN) begin
      w_packed = {1'b0, {EXP{1'b1}}, 1'b1, {(MANT-1){1'b0}}};
      w_pInx   = 1'b0;
      w_pUnf   = 1'b0;
    end else if (w_isInf) begin
      w_packed = {r_sign, {EXP{1'b1}}, {MANT{1'b0}}};
      w_pInx   = 1'b0;
      w_pUnf   = 1'b0;
    end else if (w_isZero) begin
      w_packed = {r_sign, {EXP{1'b0}}, {MANT{1'b0}}};
      w_pInx   = 1'b0;
      w_pUnf   = 1'b0;
    end else if (r_ovfIn || w_expOvf) begin
      w_packed = {r_sign, {EXP{1'b1}}, {MANT{1'b0}}};
      w_pOvf   = 1'b1;
      w_pInx   = 1'b1;
      w_pUnf   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_nextState = w_skipShift ? S_ROUND : S_SHIFT;
      S_SHIFT: if (r_remaining <= STEP_V) w_nextState = S_ROUND;
      S_ROUND: w_nextState = S_OUT;
      S_OUT:   if (out_ready) w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mant      <= '0;
      r_exp       <= '0;
      r_sign      <= 1'b0;
      r_ovfIn     <= 1'b0;
      r_sticky    <= 1'b0;
      r_speA      <= '0;
      r_speB      <= '0;
      r_type      <= '0;
      r_remaining <= '0;
      r_result    <= '0;
      r_flagOvf   <= 1'b0;
      r_flagUnf   <= 1'b0;
      r_flagInx   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_mant      <= mant_in;
          r_exp       <= exp_in;
          r_sign      <= sign_in;
          r_ovfIn     <= over_flow_in;
          r_speA      <= spe_case_a_in;
          r_speB      <= spe_case_b_in;
          r_type      <= shift_type_in;
          r_remaining <= w_clamped;
          r_sticky    <= 1'b0;
        end
        S_SHIFT: begin
          if (r_type == 2'b00) begin
            r_mant   <= w_shiftedR;
            r_sticky <= r_sticky | w_lost;
          end else begin
            r_mant <= w_shiftedL;
          end
          r_remaining <= r_remaining - w_step;
        end
        S_ROUND: begin
          r_result  <= w_packed;
          r_flagOvf <= w_pOvf;
          r_flagUnf <= w_pUnf;
          r_flagInx <= w_pInx;
        end
        default: ;
      endcase
    end
  end

  assign in_ready       = (r_state == S_IDLE);
  assign out_valid      = (r_state == S_OUT);
  assign busy           = (r_state != S_IDLE);
  assign result         = r_result;
  assign flag_overflow  = r_flagOvf;
  assign flag_underflow = r_flagUnf;
  assign flag_inexact   = r_flagInx;

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// tb_fp_mul_norm_round
// Directed vectors for fp_mul_norm_round in its binary16 configuration. A
// driver pushes the hand-computed expected result for each accepted operation
// into a queue. A monitor pops an entry and compares it whenever the DUT hands
// a result to downstream.
module tb_fp_mul_norm_round;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign_in = 1'b0;
  logic [21:0] mant_in = '0;
  logic [4:0]  exp_in = '0;
  logic        over_flow_in = 1'b0;
  logic [2:0]  spe_case_a_in = '0;
  logic [2:0]  spe_case_b_in = '0;
  logic [1:0]  shift_type_in = '0;
  logic [4:0]  shift_value_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result;
  logic        flag_overflow, flag_underflow, flag_inexact, busy;

  int checkCount = 0;
  int failCount  = 0;
  int cycCount   = 0;

  typedef struct {
    string       name;
    logic [15:0] res;
    logic        ovf;
    logic        unf;
    logic        inx;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sbQueue[$];

  fp_mul_norm_round #(.DW(16), .EXP(5), .MANT(10), .STEP(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .sign_in(sign_in), .mant_in(mant_in), .exp_in(exp_in),
    .over_flow_in(over_flow_in),
    .spe_case_a_in(spe_case_a_in), .spe_case_b_in(spe_case_b_in),
    .shift_type_in(shift_type_in), .shift_value_in(shift_value_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_overflow(flag_overflow), .flag_underflow(flag_underflow),
    .flag_inexact(flag_inexact), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycCount <= cycCount + 1;

  task automatic checkValue(input string what, input logic [31:0] act, input logic [31:0] req);
    checkCount++;
    if (act !== req) begin
      failCount++;
      $display("[TB] FAIL %s actual=%0h required=%0h", what, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkValue({e.name, " result"}, 32'(result), 32'(e.res));
    checkValue({e.name, " flag_overflow"}, 32'(flag_overflow), 32'(e.ovf));
    checkValue({e.name, " flag_underflow"}, 32'(flag_underflow), 32'(e.unf));
    checkValue({e.name, " flag_inexact"}, 32'(flag_inexact), 32'(e.inx));
    if (e.lat >= 0) checkValue({e.name, " latency"}, 32'(cycCount - e.acc), 32'(e.lat));
  endtask

  // Monitor: every handshake on the output side consumes one scoreboard entry.
  always begin
    @(negedge clk);
    #1;
    if (!rst && out_valid && out_ready) begin
      if (sbQueue.size() == 0) begin
        checkCount++;
        failCount++;
        $display("[TB] FAIL unexpected_output actual=%0h required=none", result);
      end else begin
        checkOutput(sbQueue.pop_front());
      end
    end
  end

  // Drives one operation and waits (bounded) for it to be accepted. The accept
  // cycle is returned so latency can be measured from it.
  task automatic applyStimulus(input string name, input logic s, input logic [21:0] m,
                               input logic [4:0] e, input logic ovf, input logic [2:0] a,
                               input logic [2:0] b, input logic [1:0] t, input logic [4:0] v,
                               input logic [15:0] expRes, input logic expOvf,
                               input logic expUnf, input logic expInx, input int expLat,
                               input bit push, output int accCyc);
    int   guard;
    exp_t ent;
    @(negedge clk);
    sign_in = s; mant_in = m; exp_in = e; over_flow_in = ovf;
    spe_case_a_in = a; spe_case_b_in = b; shift_type_in = t; shift_value_in = v;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checkCount++;
      failCount++;
      $display("[TB] FAIL %s accept_timeout actual=0 required=1", name);
    end
    accCyc = cycCount;
    if (push) begin
      ent = '{name: name, res: expRes, ovf: expOvf, unf: expUnf, inx: expInx,
              lat: expLat, acc: accCyc};
      sbQueue.push_back(ent);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drainQueue();
    int guard = 0;
    while (sbQueue.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (sbQueue.size() != 0) begin
      checkCount++;
      failCount++;
      $display("[TB] FAIL drain_timeout actual=%0d required=0", sbQueue.size());
    end
  endtask

  initial begin
    int acc;
    int waitCnt;

    repeat (2) @(negedge clk);
    #1;
    checkValue("reset in_ready", 32'(in_ready), 32'd1);
    checkValue("reset out_valid", 32'(out_valid), 32'd0);
    checkValue("reset busy", 32'(busy), 32'd0);
    checkValue("reset result", 32'(result), 32'd0);
    checkValue("reset flags", 32'({flag_overflow, flag_underflow, flag_inexact}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // name, sign, mant, exp, ovf, spA, spB, type, value, result, ovf, unf, inx, latency
    applyStimulus("T1_noshift", 0, 22'h240000, 5'h10, 0, 0, 0, 2'b10, 5'd0,  16'h4080, 0, 0, 0, 2, 1, acc);
    applyStimulus("T2_left1",   0, 22'h100000, 5'h0F, 0, 0, 0, 2'b01, 5'd1,  16'h3C00, 0, 0, 0, 3, 1, acc);
    applyStimulus("T3_right5",  0, 22'h100000, 5'h00, 0, 0, 0, 2'b00, 5'd5,  16'h0010, 0, 0, 0, 4, 1, acc);
    applyStimulus("T4_rnd_ovf", 0, 22'h3FFC00, 5'h1E, 0, 0, 0, 2'b10, 5'd0,  16'h7C00, 1, 0, 1, 2, 1, acc);
    applyStimulus("T7_tie_unf", 0, 22'h100000, 5'h00, 0, 0, 0, 2'b00, 5'd10, 16'h0000, 0, 1, 1, 5, 1, acc);
    applyStimulus("T8_sticky",  1, 22'h200C00, 5'h03, 0, 0, 0, 2'b00, 5'd1,  16'h8E01, 0, 0, 1, 3, 1, acc);
    applyStimulus("T9_trunc",   0, 22'h300001, 5'h05, 0, 0, 0, 2'b10, 5'd0,  16'h1600, 0, 0, 1, 2, 1, acc);
    applyStimulus("T10_clamp",  0, 22'h200000, 5'h00, 0, 0, 0, 2'b00, 5'd31, 16'h0000, 0, 1, 1, 8, 1, acc);
    applyStimulus("T11_ovf_in", 1, 22'h200000, 5'h05, 1, 0, 0, 2'b00, 5'd3,  16'hFC00, 1, 0, 1, 2, 1, acc);
    applyStimulus("T12_zero",   1, 22'h3FFC00, 5'h1E, 0, 2, 0, 2'b00, 5'd3,  16'h8000, 0, 0, 0, 2, 1, acc);
    applyStimulus("T13_inf",    0, 22'h200000, 5'h05, 1, 0, 3, 2'b01, 5'd2,  16'h7C00, 0, 0, 0, 2, 1, acc);
    drainQueue();

    // inf * zero with downstream stalled: the NaN result must be held steady.
    out_ready = 1'b0;
    applyStimulus("T5_nan_hold", 0, 22'h000000, 5'h00, 0, 3, 2, 2'b10, 5'd0, 16'h7E00, 0, 0, 0, -1, 1, acc);
    #1;
    waitCnt = 0;
    while (!out_valid && waitCnt < 50) begin
      @(negedge clk);
      #1;
      waitCnt++;
    end
    checkValue("T5 latency", 32'(cycCount - acc), 32'd2);
    for (int i = 0; i < 3; i++) begin
      checkValue("T5 held result", 32'(result), 32'h7E00);
      checkValue("T5 held out_valid", 32'(out_valid), 32'd1);
      checkValue("T5 held in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      if (i < 2) #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    checkValue("T5 idle in_ready", 32'(in_ready), 32'd1);
    checkValue("T5 idle out_valid", 32'(out_valid), 32'd0);
    drainQueue();

    // Abort a long right shift with reset: nothing may come out afterwards.
    applyStimulus("T6_abort", 0, 22'h200000, 5'h05, 0, 0, 0, 2'b00, 5'd20, 16'h0000, 0, 0, 0, 0, 0, acc);
    #1;
    checkValue("T6 busy in shift", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkValue("T6 reset out_valid", 32'(out_valid), 32'd0);
    checkValue("T6 reset busy", 32'(busy), 32'd0);
    checkValue("T6 reset result", 32'(result), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkValue("T6 in_ready after release", 32'(in_ready), 32'd1);
    repeat (10) @(negedge clk);
    applyStimulus("T6_next", 0, 22'h240000, 5'h10, 0, 0, 0, 2'b10, 5'd0, 16'h4080, 0, 0, 0, 2, 1, acc);
    drainQueue();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
